// File: rtl/fact_dp.sv
// Iterative factorial datapath: down-counter, product register and output buffer,
// driven by the control word of the factorial control FSM.
module fact_dp #(
   parameter int WIDTH = 32,
   parameter int NBITS = 4
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [NBITS-1:0] n,
   input  logic             cld,
   input  logic             cen,
   input  logic             s1,
   input  logic             ren,
   input  logic             ben,
   output logic             greater,
   output logic [WIDTH-1:0] result,
   output logic             ovf
);

   localparam logic [NBITS-1:0] CNT_ONE  = {{(NBITS-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] PROD_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [NBITS-1:0]       cnt_q,     cnt_d;
   logic [WIDTH-1:0]       prod_q,    prod_d;
   logic                   ovf_int_q, ovf_int_d;
   logic [WIDTH-1:0]       result_q,  result_d;
   logic                   ovf_q,     ovf_d;
   logic [WIDTH+NBITS-1:0] mul_full;

   // Full-width product so the bits that fall off the register can raise the overflow flag
   assign mul_full = {{NBITS{1'b0}}, prod_q} * {{WIDTH{1'b0}}, cnt_q};

   always_comb begin
      cnt_d     = cnt_q;
      prod_d    = prod_q;
      ovf_int_d = ovf_int_q;
      result_d  = result_q;
      ovf_d     = ovf_q;

      if (cen) begin
         if (cld) begin
            cnt_d = n;
         end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
         end
      end

      if (ren) begin
         if (!s1) begin
            prod_d    = PROD_ONE;
            ovf_int_d = 1'b0;
         end else begin
            prod_d = mul_full[WIDTH-1:0];
            if (|mul_full[WIDTH+NBITS-1:WIDTH]) begin
               ovf_int_d = 1'b1;
            end
         end
      end

      if (ben) begin
         result_d = prod_q;
         ovf_d    = ovf_int_q;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         cnt_q     <= '0;
         prod_q    <= '0;
         ovf_int_q <= 1'b0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         prod_q    <= prod_d;
         ovf_int_q <= ovf_int_d;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
      end
   end

   assign greater = (cnt_q > CNT_ONE);
   assign result  = result_q;
   assign ovf     = ovf_q;

endmodule

// File: doc/fact_dp.md
Name: fact_dp

Overview:
- Datapath for the iterative factorial unit. It sits directly downstream of the factorial control FSM.
- It consumes that FSM's control word (cld, cen, s1, ren, ben) and returns the `greater` status bit that drives the FSM's Wait-state branch.
- It computes n! with a down-counter, a product register and an output buffer register.
- It also flags when the product no longer fits in WIDTH bits.

Parameters:
- WIDTH, 32, width of product register and result.
- NBITS, 4, width of operand n and of the down-counter.

Ports:
- Clk  in  1  system clock, all state updates on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- n  in  NBITS  operand; sampled only on load.
- cld  in  1  counter load select.
- cen  in  1  counter enable.
- s1  in  1  product mux select (0: constant 1, 1: product*count).
- ren  in  1  product register enable.
- ben  in  1  output buffer enable.
- greater  out  1  combinational, 1 when count > 1.
- result  out  WIDTH  buffered factorial result.
- ovf  out  1  buffered overflow flag for result.

Behaviour:
- Reset (Rst low, asynchronous, any cycle, including mid-computation):
  - cnt=0, prod=0, ovf_int=0, result=0, ovf=0.
  - After reset release, greater=0 (cnt=0).
- Counter cnt[NBITS-1:0], evaluated in priority order:
  - cen=1 and cld=1: cnt <= n.
  - cen=1 and cld=0: cnt <= cnt-1 when cnt!=0. At cnt==0 it holds 0 (saturates, no wrap).
  - cen=0: hold. cld alone has no effect.
- Product register prod[WIDTH-1:0]:
  - ren=1, s1=0: prod <= 1, and ovf_int <= 0.
  - ren=1, s1=1: prod <= low WIDTH bits of (prod * cnt), computed at full WIDTH+NBITS width.
    - If any upper NBITS bits of the full product are nonzero, ovf_int <= 1.
    - ovf_int is sticky until the next s1=0 load.
  - ren=0: hold prod and ovf_int.
  - Multiply and decrement in the same cycle both use the pre-edge cnt.
- greater = (cnt > 1):
  - Purely combinational from the cnt register, with no dependency on control inputs.
  - Valid one cycle after any cnt update.
- Output buffer: ben=1 gives result <= prod and ovf <= ovf_int. ben=0 holds. result and ovf change only on ben cycles.
- Control word per FSM state ({cld,cen,s1,ren,ben}):
  - Load=11010.
  - Wait=00000.
  - Dec=01110.
  - Done=00001.
  - Idle=00000.
- Any other combination of control inputs is still honoured bit by bit per the rules above. No illegal states exist.
- Timing for n>1: Load (1 cycle) + (n-1) x (Wait+Dec) + Wait + Done. result is valid the cycle after Done, i.e. 2n+1 cycles after the Load edge.
- Boundary cases:
  - n=0 and n=1: greater=0 right after Load, so the FSM goes straight to Done and result=1.
  - n=2^NBITS-1 (15 at default): computes normally. ovf=1 because 15! > 2^32.
  - Consecutive jobs: a new Load (s1=0, ren=1) reinitialises prod and ovf_int. The previous result stays held until the next ben.
- Single clock domain; no internal FSM. Sequencing belongs to the control FSM.

Test Plan:
- Reset: drive Rst low mid-Dec with cnt=3, prod=4 -> immediately cnt=0, prod=0, result=0, ovf=0, greater=0, with no clock edge required.
- n=5 run with FSM control-word sequence:
  - Load -> cnt=5, prod=1, greater=1.
  - After 4 Dec cycles -> cnt=1, prod=120, greater=0.
  - Done -> result=120, ovf=0.
- n=0 and n=1: Load -> greater=0. Done -> result=1, ovf=0 in both cases, and cnt stays 0/1 without wrap.
- Overflow: n=13 at WIDTH=32 -> result=13! mod 2^32 = 1932053504, ovf=1. A following n=12 job -> result=479001600, ovf=0.
- Saturation and hold:
  - cnt=0 with cen=1, cld=0 for 3 cycles -> cnt stays 0.
  - cld=1 with cen=0 -> cnt unchanged.
  - ren=0 -> prod unchanged.
  - ben=0 between jobs -> result unchanged.
- Same-edge ordering: cnt=3, prod=2, control Dec -> next cycle prod=6 (uses old cnt=3), cnt=2, greater=1.
